// File: rtl/mflux_pkg.sv
// Shared helpers for the tagged multi-queue channel: tag/count widths and a DEPTH sanity check.
// Contains no logic; the MFLUX_IS_POW2 macro is defined here for the queue elaboration check.
`define MFLUX_IS_POW2(d) (((d) >= 2) && ((((d) - 1) & (d)) == 0))

package mflux_pkg;

  // Width of the tag field. It is at least one bit, so a single-flux build still has a tag.
  function automatic int tag_w(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  // Occupancy counter width. It has one extra bit, so the value DEPTH can be represented.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_DEPTH = 16;
  typedef logic [$clog2(DEF_DEPTH):0] cnt_t;

endpackage

// File: rtl/single_flux_fifo.sv
// One FWFT queue: a pushed word is visible at head_o from the next cycle, and there is no bypass.
// push is ignored while full_o is set and pop is ignored while empty_o is set; both flags come from registers only.
module single_flux_fifo
  import mflux_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  typedef logic [CW-1:0] qcnt_t;

  if (!`MFLUX_IS_POW2(DEPTH)) begin : g_depth_chk
    $error("single_flux_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  qcnt_t                 count_q, count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == qcnt_t'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap at DEPTH without any extra logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + qcnt_t'(1);
      2'b01:   count_d = count_q - qcnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/multi_flux_fifo.sv
// FLUX tagged FWFT queues behind one {tag,data} write port; dout shows the lowest-index non-empty head, with no added latency.
// The global full flag blocks every write, and writes with an out-of-range tag are dropped. The sticky err output exists only when MFIFO_ERR_CHECK_EN is defined.
module multi_flux_fifo
  import mflux_pkg::*;
#(
  parameter  int FLUX       = 2,
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int TAG_WIDTH  = tag_w(FLUX),
  localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic [FLUX-1:0]  read,
  output logic [FLUX-1:0]  empty,
  output logic [WIDTH-1:0] dout,
  output logic             err
);
  logic [TAG_WIDTH-1:0]  tag;
  logic [FLUX-1:0]       sel, q_full, q_empty;
  logic [DATA_WIDTH-1:0] head [FLUX];
  logic                  wr_ok;

  assign tag   = din[WIDTH-1 -: TAG_WIDTH];
  assign full  = |q_full;
  assign empty = q_empty;
  assign wr_ok = write && !full;

  // A tag that matches no queue leaves sel at all zeros, so that write is dropped.
  for (genvar i = 0; i < FLUX; i++) begin : g_flux
    assign sel[i] = (tag == TAG_WIDTH'(i));
    single_flux_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_q (
      .clk    (clk),
      .rst    (rst),
      .push_i (wr_ok && sel[i]),
      .pop_i  (read[i]),
      .din_i  (din[DATA_WIDTH-1:0]),
      .head_o (head[i]),
      .empty_o(q_empty[i]),
      .full_o (q_full[i])
    );
  end

  always_comb begin
    dout = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (!q_empty[i]) dout = {TAG_WIDTH'(i), head[i]};
    end
  end

`ifdef MFIFO_ERR_CHECK_EN
  logic err_q, err_d, bad;

  assign bad   = (write && full) || (write && ~|sel) || |(read & q_empty);
  assign err_d = err_q || bad;
  assign err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && bad) $error("multi_flux_fifo: protocol violation write=%b full=%b tag=%0d read=%b empty=%b",
                            write, full, tag, read, q_empty);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_flux_fifo.sv
// Bench for multi_flux_fifo: directed steps plus randomized traffic, checked against a model of per-flux queues.
module tb_multi_flux_fifo;
  localparam int FLUX  = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TW    = 1;
  localparam int W     = DW + TW;

  logic            clk = 1'b0;
  logic            rst;
  logic            write;
  logic [W-1:0]    din;
  logic            full;
  logic [FLUX-1:0] read;
  logic [FLUX-1:0] empty;
  logic [W-1:0]    dout;
  logic            err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mq [FLUX][$];
  logic          err_m = 1'b0;

  always #5 clk = ~clk;

  multi_flux_fifo #(.FLUX(FLUX), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .write(write),
    .din  (din),
    .full (full),
    .read (read),
    .empty(empty),
    .dout (dout),
    .err  (err)
  );

  function automatic logic [FLUX-1:0] m_empty();
    logic [FLUX-1:0] e;
    for (int i = 0; i < FLUX; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  function automatic logic m_full();
    logic f = 1'b0;
    for (int i = 0; i < FLUX; i++) if (mq[i].size() == DEPTH) f = 1'b1;
    return f;
  endfunction

  function automatic logic [W-1:0] m_dout();
    for (int i = 0; i < FLUX; i++) begin
      if (mq[i].size() != 0) return {TW'(i), mq[i][0]};
    end
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".empty"}, W'(empty), W'(m_empty()));
    chk({where, ".full"},  W'(full),  W'(m_full()));
    chk({where, ".dout"},  dout,      m_dout());
    chk({where, ".err"},   W'(err),   W'(err_m));
  endtask

  // Drive one cycle of inputs, let the edge happen, then update the model and compare.
  task automatic step(input logic wr, input logic [W-1:0] d, input logic [FLUX-1:0] rd, input string where);
    logic            mfull;
    logic [FLUX-1:0] mempty;
    int              t;
    write  = wr;
    din    = d;
    read   = rd;
    mfull  = m_full();
    mempty = m_empty();
    t      = int'(d[W-1 -: TW]);
    @(posedge clk);
    #1;
    for (int i = 0; i < FLUX; i++) begin
      if (rd[i] && !mempty[i]) void'(mq[i].pop_front());
    end
    if (wr && !mfull && t < FLUX) mq[t].push_back(d[DW-1:0]);
`ifdef MFIFO_ERR_CHECK_EN
    if ((wr && mfull) || (wr && t >= FLUX) || |(rd & mempty)) err_m = 1'b1;
`endif
    write = 1'b0;
    read  = '0;
    check_outputs(where);
  endtask

  task automatic async_reset(input string where);
    rst = 1'b1;
    #1;
    for (int i = 0; i < FLUX; i++) mq[i].delete();
    err_m = 1'b0;
    check_outputs(where);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int              wp, rp;
  logic            wr;
  logic [FLUX-1:0] rd;

  initial begin
    write = 1'b0;
    din   = '0;
    read  = '0;
    async_reset("reset");

    step(1'b1, {1'b0, 8'h11}, 2'b00, "fwft_w1");
    step(1'b1, {1'b0, 8'h22}, 2'b00, "fwft_w2");
    step(1'b0, '0,            2'b01, "fwft_r1");
    step(1'b0, '0,            2'b01, "fwft_r2");

    step(1'b1, {1'b1, 8'hAA}, 2'b00, "prio_w1");
    step(1'b1, {1'b0, 8'h55}, 2'b00, "prio_w0");
    step(1'b0, '0,            2'b01, "prio_pop0");
    step(1'b0, '0,            2'b10, "prio_pop1");

    for (int k = 0; k < DEPTH; k++) step(1'b1, {1'b1, 8'(k * 7 + 3)}, 2'b00, "full_fill");
    step(1'b1, {1'b1, 8'hFF}, 2'b00, "full_reject");
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 2'b10, "full_drain");

    for (int k = 0; k < 3; k++) step(1'b1, {1'b0, 8'(8'h30 + k)}, 2'b00, "sim_fill3");
    step(1'b1, {1'b0, 8'h3F}, 2'b01, "sim_wr_rd3");
    for (int k = 0; k < 3; k++) step(1'b0, '0, 2'b01, "sim_drain3");
    for (int k = 0; k < DEPTH; k++) step(1'b1, {1'b0, 8'(8'h80 + k)}, 2'b00, "sim_fill16");
    step(1'b1, {1'b0, 8'hEE}, 2'b01, "sim_wr_rd16");
    step(1'b1, {1'b1, 8'h77}, 2'b00, "sim_after15");
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 2'b11, "sim_drain_both");

    step(1'b0, '0, 2'b10, "err_rd_empty");
    step(1'b0, '0, 2'b00, "err_hold");

    for (int k = 0; k < 5; k++) step(1'b1, {TW'(k % 2), 8'(8'hC0 + k)}, 2'b00, "rst_prefill");
    async_reset("rst_mid");

    for (int k = 0; k < 400; k++) begin
      wp = (k < 200) ? 85 : 30;
      rp = (k < 200) ? 20 : 70;
      wr = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < rp) ? FLUX'($urandom) : '0;
      if (k == 300) async_reset("rand_rst");
      step(wr, {TW'($urandom_range(0, FLUX - 1)), DW'($urandom)}, rd, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
